instruction_compressor: RTL and testbench

INSTRUCTION_COMPRESSOR -- requirements
Module: instruction_compressor

---
 rtl/instruction_compressor_pkg.sv | 55 +++++
 rtl/instruction_compressor_rvc_compress.sv | 135 +++++++++++++
 rtl/instruction_compressor.sv | 125 ++++++++++++
 tb/tb_instruction_compressor.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_compressor_pkg.sv
// rtl/instruction_compressor_pkg.sv - shared encodings and types for the RV32I-to-RVC packer
package instruction_compressor_pkg;

  // RV32I major opcodes recognised by the compressor
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_JALR   = 7'h67;

  // RV32I funct3 values
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRX    = 3'b101;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // RV32I funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // RVC quadrants
  localparam logic [1:0] Q0        = 2'b00;
  localparam logic [1:0] Q1        = 2'b01;
  localparam logic [1:0] Q2        = 2'b10;

  // RVC funct3 values
  localparam logic [2:0] CF3_LW    = 3'b010;
  localparam logic [2:0] CF3_SW    = 3'b110;
  localparam logic [2:0] CF3_ADDI  = 3'b000;
  localparam logic [2:0] CF3_LUI   = 3'b011;
  localparam logic [2:0] CF3_MISC  = 3'b100;
  localparam logic [2:0] CF3_SLLI  = 3'b000;
  localparam logic [2:0] CF3_JALR  = 3'b100;

  // Fixed halfwords and the one fixed 32-bit pattern
  localparam logic [15:0] C_NOP       = 16'h0001;
  localparam logic [15:0] C_EBREAK    = 16'h9002;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_ALIGNED = 2'd0,
    ST_HALF    = 2'd1,
    ST_FLUSH   = 2'd2
  } pack_state_e;

  // Registers x8..x15 are the only ones reachable by 3-bit RVC fields
  function automatic logic is_prime_reg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/instruction_compressor_rvc_compress.sv
// rtl/instruction_compressor_rvc_compress.sv - stateless RV32I to RVC matcher and encoder
module rvc_compress
  import instruction_compressor_pkg::*;
(
  input  logic [31:0] inst,
  output logic        ok,
  output logic [15:0] c
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        rd_p;
  logic        rs1_p;
  logic        rs2_p;
  logic        imm_i_6bit;
  logic        lw_off_ok;
  logic        sw_off_ok;
  logic        lui_imm_ok;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign imm_i  = inst[31:20];
  assign imm_s  = {inst[31:25], inst[11:7]};

  assign rd_p  = is_prime_reg(rd);
  assign rs1_p = is_prime_reg(rs1);
  assign rs2_p = is_prime_reg(rs2);

  // Immediate fits a signed 6-bit field when bits 11..5 are a pure sign extension
  assign imm_i_6bit = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

  // Word offsets 0..124: bits above 6 clear and word aligned
  assign lw_off_ok = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
  assign sw_off_ok = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);

  // LUI upper immediate must be a sign-extended 6-bit nonzero value
  assign lui_imm_ok = ((inst[31:17] == 15'h0000) || (inst[31:17] == 15'h7fff)) &&
                      (inst[31:12] != 20'd0);

  // Match one compressible row and build its standard RVC encoding
  always_comb begin
    ok = 1'b0;
    c  = 16'h0000;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == F3_WORD && rd_p && rs1_p && lw_off_ok) begin
          ok = 1'b1;
          c  = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], Q0};
        end
      end
      OP_STORE: begin
        if (funct3 == F3_WORD && rs1_p && rs2_p && sw_off_ok) begin
          ok = 1'b1;
          c  = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], Q0};
        end
      end
      OP_LUI: begin
        if (rd != 5'd0 && rd != 5'd2 && lui_imm_ok) begin
          ok = 1'b1;
          c  = {CF3_LUI, inst[17], rd, inst[16:12], Q1};
        end
      end
      OP_IMM: begin
        case (funct3)
          F3_ADD: begin
            if (rd == rs1 && rd != 5'd0 && imm_i_6bit && imm_i != 12'd0) begin
              ok = 1'b1;
              c  = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], Q1};
            end
          end
          F3_SLL: begin
            if (funct7 == F7_BASE && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
              ok = 1'b1;
              c  = {CF3_SLLI, 1'b0, rd, rs2, Q2};
            end
          end
          F3_SRX: begin
            if ((funct7 == F7_BASE || funct7 == F7_ALT) && rd == rs1 && rd_p &&
                rs2 != 5'd0) begin
              ok = 1'b1;
              c  = {CF3_MISC, 1'b0, 1'b0, funct7 == F7_ALT, rd[2:0], rs2, Q1};
            end
          end
          F3_AND: begin
            if (rd == rs1 && rd_p && imm_i_6bit) begin
              ok = 1'b1;
              c  = {CF3_MISC, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], Q1};
            end
          end
          default: ok = 1'b0;
        endcase
      end
      OP_OP: begin
        if (rd == rs1 && rd_p && rs2_p) begin
          if (funct7 == F7_ALT && funct3 == F3_ADD) begin
            ok = 1'b1;
            c  = {CF3_MISC, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], Q1};
          end else if (funct7 == F7_BASE && funct3 == F3_XOR) begin
            ok = 1'b1;
            c  = {CF3_MISC, 1'b0, 2'b11, rd[2:0], 2'b01, rs2[2:0], Q1};
          end else if (funct7 == F7_BASE && funct3 == F3_OR) begin
            ok = 1'b1;
            c  = {CF3_MISC, 1'b0, 2'b11, rd[2:0], 2'b10, rs2[2:0], Q1};
          end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
            ok = 1'b1;
            c  = {CF3_MISC, 1'b0, 2'b11, rd[2:0], 2'b11, rs2[2:0], Q1};
          end
        end
      end
      OP_JALR: begin
        if (funct3 == F3_ADD && rd == 5'd1 && rs1 != 5'd0 && imm_i == 12'd0) begin
          ok = 1'b1;
          c  = {CF3_JALR, 1'b1, rs1, 5'd0, Q2};
        end
      end
      default: begin
        if (inst == INST_EBREAK) begin
          ok = 1'b1;
          c  = C_EBREAK;
        end
      end
    endcase
  end

endmodule

// File: rtl/instruction_compressor.sv
// rtl/instruction_compressor.sv - packs an RV32I stream into mixed 16/32-bit memory words
module instruction_compressor
  import instruction_compressor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic [15:0] comp_count
);

  pack_state_e state;
  pack_state_e state_nx;
  logic [15:0] pend;
  logic [15:0] pend_nx;
  logic        c_ok;
  logic [15:0] c_half;
  logic        out_free;
  logic        accept;
  logic        load;
  logic [31:0] word_nx;
  logic        last_nx;

  rvc_compress u_rvc (
    .inst (in_inst),
    .ok   (c_ok),
    .c    (c_half)
  );

  // Output register can take a new word when empty or being drained this cycle
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state != ST_FLUSH) && out_free;
  assign accept   = in_valid && in_ready;

  // State, pending halfword and pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ALIGNED;
      pend  <= 16'h0000;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  // Packing decisions: where the accepted instruction lands and what word is emitted
  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    load     = 1'b0;
    word_nx  = out_word;
    last_nx  = out_last;
    case (state)
      ST_ALIGNED: begin
        if (accept) begin
          if (c_ok) begin
            pend_nx  = c_half;
            state_nx = in_last ? ST_FLUSH : ST_HALF;
          end else begin
            load    = 1'b1;
            word_nx = in_inst;
            last_nx = in_last;
          end
        end
      end
      ST_HALF: begin
        if (accept) begin
          load = 1'b1;
          if (c_ok) begin
            word_nx  = {c_half, pend};
            last_nx  = in_last;
            state_nx = ST_ALIGNED;
          end else begin
            // Upper half of the 32-bit instruction spills into the next word
            word_nx  = {in_inst[15:0], pend};
            last_nx  = 1'b0;
            pend_nx  = in_inst[31:16];
            state_nx = in_last ? ST_FLUSH : ST_HALF;
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          load     = 1'b1;
          word_nx  = {C_NOP, pend};
          last_nx  = 1'b1;
          pend_nx  = 16'h0000;
          state_nx = ST_ALIGNED;
        end
      end
      default: state_nx = ST_ALIGNED;
    endcase
  end

  // Registered output word; only reloaded when the slot is free, so it holds under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= 32'h0000_0000;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_word  <= word_nx;
      out_last  <= last_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of instructions accepted in compressed form
  always_ff @(posedge clk) begin
    if (rst) begin
      comp_count <= 16'h0000;
    end else if (accept && c_ok && comp_count != 16'hffff) begin
      comp_count <= comp_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_instruction_compressor.sv
// tb/tb_instruction_compressor.sv - randomized and directed bench for instruction_compressor
module tb_instruction_compressor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic [15:0] comp_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  logic [31:0] stim_q[$];
  logic [31:0] got_w[$];
  logic        got_l[$];
  logic [31:0] exp_w[$];
  logic        exp_l[$];

  instruction_compressor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_last   (out_last),
    .comp_count (comp_count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mk_i(input int imm, input int rs1, input int f3,
                                       input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] mk_s(input int imm, input int rs2, input int rs1,
                                       input int f3, input int op);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] mk_r(input int f7, input int rs2, input int rs1,
                                       input int f3, input int rd, input int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] mk_u(input int imm20, input int rd, input int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  // Reference compressor: decode fields to integers and apply the row conditions
  function automatic bit ref_compress(input logic [31:0] i, output logic [15:0] c);
    int op, rd, rs1, rs2, f3, f7, imm_i, imm_s, imm_u;
    logic [6:0] o7;
    logic [5:0] s6;
    bit rdp, rs1p, rs2p;
    op = i[6:0]; rd = i[11:7]; rs1 = i[19:15]; rs2 = i[24:20];
    f3 = i[14:12]; f7 = i[31:25];
    imm_i = $signed(i[31:20]);
    imm_s = $signed({i[31:25], i[11:7]});
    imm_u = $signed(i[31:12]);
    rdp  = rd >= 8 && rd <= 15;
    rs1p = rs1 >= 8 && rs1 <= 15;
    rs2p = rs2 >= 8 && rs2 <= 15;
    c = 16'h0;
    if (i == 32'h00100073) begin c = 16'h9002; return 1; end
    if (op == 'h03 && f3 == 2 && rdp && rs1p && imm_i >= 0 && imm_i <= 124 && imm_i % 4 == 0) begin
      o7 = imm_i[6:0];
      c = {3'b010, o7[5:3], rs1[2:0], o7[2], o7[6], rd[2:0], 2'b00};
      return 1;
    end
    if (op == 'h23 && f3 == 2 && rs1p && rs2p && imm_s >= 0 && imm_s <= 124 && imm_s % 4 == 0) begin
      o7 = imm_s[6:0];
      c = {3'b110, o7[5:3], rs1[2:0], o7[2], o7[6], rs2[2:0], 2'b00};
      return 1;
    end
    if (op == 'h37 && rd != 0 && rd != 2 && imm_u >= -32 && imm_u <= 31 && imm_u != 0) begin
      s6 = imm_u[5:0];
      c = {3'b011, s6[5], rd[4:0], s6[4:0], 2'b01};
      return 1;
    end
    if (op == 'h13) begin
      s6 = imm_i[5:0];
      if (f3 == 0 && rd == rs1 && rd != 0 && imm_i >= -32 && imm_i <= 31 && imm_i != 0) begin
        c = {3'b000, s6[5], rd[4:0], s6[4:0], 2'b01};
        return 1;
      end
      if (f3 == 1 && f7 == 0 && rd == rs1 && rd != 0 && rs2 >= 1) begin
        c = {3'b000, 1'b0, rd[4:0], rs2[4:0], 2'b10};
        return 1;
      end
      if (f3 == 5 && (f7 == 0 || f7 == 32) && rd == rs1 && rdp && rs2 >= 1) begin
        c = {3'b100, 1'b0, (f7 == 32) ? 2'b01 : 2'b00, rd[2:0], rs2[4:0], 2'b01};
        return 1;
      end
      if (f3 == 7 && rd == rs1 && rdp && imm_i >= -32 && imm_i <= 31) begin
        c = {3'b100, s6[5], 2'b10, rd[2:0], s6[4:0], 2'b01};
        return 1;
      end
    end
    if (op == 'h33 && rd == rs1 && rdp && rs2p) begin
      if (f7 == 32 && f3 == 0) begin c = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01}; return 1; end
      if (f7 == 0 && f3 == 4)  begin c = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01}; return 1; end
      if (f7 == 0 && f3 == 6)  begin c = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01}; return 1; end
      if (f7 == 0 && f3 == 7)  begin c = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01}; return 1; end
    end
    if (op == 'h67 && f3 == 0 && rd == 1 && rs1 != 0 && imm_i == 0) begin
      c = {4'b1001, rs1[4:0], 5'd0, 2'b10};
      return 1;
    end
    return 0;
  endfunction

  // Compressed-instruction decoder used for round-trip checks
  function automatic logic [31:0] expand(input logic [15:0] c);
    int q, f3, rdp, rs1p, r5, imm6, sh, off;
    q = c[1:0]; f3 = c[15:13];
    rdp = 8 + int'(c[4:2]); rs1p = 8 + int'(c[9:7]);
    r5 = c[11:7]; imm6 = $signed({c[12], c[6:2]}); sh = c[6:2];
    off = {c[5], c[12:10], c[6], 2'b00};
    if (q == 0 && f3 == 2) return mk_i(off, rs1p, 2, rdp, 'h03);
    if (q == 0 && f3 == 6) return mk_s(off, rdp, rs1p, 2, 'h23);
    if (q == 1 && f3 == 0) return mk_i(imm6, r5, 0, r5, 'h13);
    if (q == 1 && f3 == 3) return mk_u(imm6, r5, 'h37);
    if (q == 1 && f3 == 4) begin
      case (c[11:10])
        2'b00: return mk_i(sh, rs1p, 5, rs1p, 'h13);
        2'b01: return mk_i(1024 + sh, rs1p, 5, rs1p, 'h13);
        2'b10: return mk_i(imm6, rs1p, 7, rs1p, 'h13);
        default: begin
          case (c[6:5])
            2'b00: return mk_r(32, rdp, rs1p, 0, rs1p, 'h33);
            2'b01: return mk_r(0, rdp, rs1p, 4, rs1p, 'h33);
            2'b10: return mk_r(0, rdp, rs1p, 6, rs1p, 'h33);
            default: return mk_r(0, rdp, rs1p, 7, rs1p, 'h33);
          endcase
        end
      endcase
    end
    if (q == 2 && f3 == 0) return mk_i(sh, r5, 1, r5, 'h13);
    if (q == 2 && f3 == 4) begin
      if (c == 16'h9002) return 32'h00100073;
      if (c[12] == 1'b1 && sh == 0 && r5 != 0) return mk_i(0, r5, 0, 1, 'h67);
    end
    return 32'h0;
  endfunction

  // Random instruction satisfying one compressible row (0..13)
  function automatic logic [31:0] gen_row(input int r);
    int a, b, x, sh, imm;
    a = 8 + int'($urandom_range(0, 7));
    b = 8 + int'($urandom_range(0, 7));
    x = int'($urandom_range(1, 31));
    sh = int'($urandom_range(1, 31));
    imm = int'($urandom_range(0, 63)) - 32;
    case (r)
      0:  return mk_i(4 * int'($urandom_range(0, 31)), b, 2, a, 'h03);
      1:  return mk_s(4 * int'($urandom_range(0, 31)), a, b, 2, 'h23);
      2:  return mk_i((imm == 0) ? 31 : imm, x, 0, x, 'h13);
      3:  return mk_u((imm == 0) ? -32 : imm, (x == 2) ? 3 : x, 'h37);
      4:  return mk_i(sh, a, 5, a, 'h13);
      5:  return mk_i(1024 + sh, a, 5, a, 'h13);
      6:  return mk_i(imm, a, 7, a, 'h13);
      7:  return mk_r(32, b, a, 0, a, 'h33);
      8:  return mk_r(0, b, a, 4, a, 'h33);
      9:  return mk_r(0, b, a, 6, a, 'h33);
      10: return mk_r(0, b, a, 7, a, 'h33);
      11: return mk_i(sh, x, 1, x, 'h13);
      12: return mk_i(0, x, 0, 1, 'h67);
      default: return 32'h00100073;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_inst = 32'h0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 0;
  endtask

  // Expected words: halfword stream, padded with C.NOP when odd, paired little-endian
  task automatic build_model();
    logic [15:0] hq[$];
    logic [15:0] c;
    exp_w.delete(); exp_l.delete();
    foreach (stim_q[i]) begin
      if (ref_compress(stim_q[i], c)) begin
        hq.push_back(c);
        if (exp_count < 65535) exp_count++;
      end else begin
        hq.push_back(stim_q[i][15:0]);
        hq.push_back(stim_q[i][31:16]);
      end
    end
    if (hq.size() % 2 == 1) hq.push_back(16'h0001);
    for (int k = 0; k < hq.size(); k += 2) begin
      exp_w.push_back({hq[k+1], hq[k]});
      exp_l.push_back(k + 2 == hq.size());
    end
  endtask

  // Drive stim_q as one stream with random output backpressure and score the result
  task automatic run_stream(input int rdy_pct);
    build_model();
    got_w.delete(); got_l.delete();
    fork
      begin : drv
        for (int i = 0; i < stim_q.size(); i++) begin
          int w;
          bit acc;
          w = 0; acc = 0;
          in_valid = 1'b1; in_inst = stim_q[i]; in_last = (i == stim_q.size() - 1);
          while (!acc && w < 3000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            w++;
          end
          if (!acc) begin
            chk("input_accept_timeout", 32'd0, 32'd1);
            break;
          end
        end
        in_valid = 1'b0; in_last = 1'b0;
      end
      begin : col
        int cyc;
        bit done, hold;
        logic [31:0] hw;
        logic hl;
        cyc = 0; done = 0; hold = 0; hw = 32'h0; hl = 1'b0;
        while (!done && cyc < 3000) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(1, 100) <= rdy_pct);
          @(negedge clk);
          cyc++;
          if (hold && out_valid) begin
            chk("stall_word_stable", out_word, hw);
            chk("stall_last_stable", out_last, hl);
          end
          hold = 0;
          if (out_valid && out_ready) begin
            got_w.push_back(out_word); got_l.push_back(out_last);
            if (out_last) done = 1;
          end else if (out_valid) begin
            hold = 1; hw = out_word; hl = out_last;
          end
        end
        if (!done) chk("output_last_timeout", 32'd0, 32'd1);
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    chk("word_count", got_w.size(), exp_w.size());
    for (int k = 0; k < got_w.size() && k < exp_w.size(); k++) begin
      chk($sformatf("word[%0d]", k), got_w[k], exp_w[k]);
      chk($sformatf("last[%0d]", k), got_l[k], exp_l[k]);
    end
    chk("comp_count", comp_count, exp_count);
  endtask

  logic [31:0] nc_tab[$];
  logic [31:0] edge_tab[$];
  logic [31:0] inst_v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_last = 1'b0; out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_word", out_word, 32'h0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_comp_count", comp_count, 16'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Two c.addi fill one word
    stim_q = '{32'h00540413, 32'h00540413};
    run_stream(100);
    if (got_w.size() >= 1) chk("addi_pair_word", got_w[0], 32'h04150415);
    if (got_l.size() >= 1) chk("addi_pair_last", got_l[0], 1'b1);
    chk("addi_pair_count", comp_count, 16'd2);

    // c.lw followed by a 32-bit add that straddles, then NOP padding
    stim_q = '{32'h00452483, 32'h007302B3};
    run_stream(100);
    if (got_w.size() >= 2) begin
      chk("lw_add_word0", got_w[0], 32'h02B34144);
      chk("lw_add_last0", got_l[0], 1'b0);
      chk("lw_add_word1", got_w[1], 32'h00010073);
      chk("lw_add_last1", got_l[1], 1'b1);
    end

    // Lone uncompressed last instruction from ALIGNED
    do_reset();
    stim_q = '{32'h007302B3};
    run_stream(100);
    if (got_w.size() >= 1) chk("lone_add_word", got_w[0], 32'h007302B3);
    chk("lone_add_count", comp_count, 16'd0);

    // Backpressure: output held for three cycles, second input waits
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h007302B3; in_last = 1'b0;
    @(posedge clk); #1;
    in_inst = 32'h00A00093; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_word", out_word, 32'h007302B3);
      chk("stall_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("release_valid", out_valid, 1'b1);
    chk("release_word", out_word, 32'h00A00093);
    chk("release_last", out_last, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drained_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Reset while flushing discards the pending halfword
    in_valid = 1'b1; in_inst = 32'h00540413; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_count", comp_count, 16'd1);
    @(posedge clk); #1;
    rst = 1'b0; exp_count = 0;
    @(negedge clk);
    chk("flush_rst_valid", out_valid, 1'b0);
    chk("flush_rst_count", comp_count, 16'd0);
    chk("flush_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    stim_q = '{32'h00540413, 32'h007302B3};
    run_stream(100);
    if (got_w.size() >= 2) begin
      chk("post_rst_word0", got_w[0], 32'h02B30415);
      chk("post_rst_word1", got_w[1], 32'h00010073);
    end

    // Round trip: every row plus boundary immediates, each alone with in_last
    edge_tab = '{mk_i(124, 9, 2, 8, 'h03), mk_i(0, 15, 2, 15, 'h03), mk_s(124, 8, 15, 2, 'h23),
                 mk_i(-32, 5, 0, 5, 'h13), mk_i(31, 5, 0, 5, 'h13), mk_i(-32, 9, 7, 9, 'h13),
                 mk_i(0, 9, 7, 9, 'h13), mk_i(31, 31, 1, 31, 'h13), mk_u(31, 1, 'h37),
                 mk_u(-32, 31, 'h37), mk_i(1024 + 31, 15, 5, 15, 'h13)};
    for (int r = 0; r < 14; r++) begin
      for (int n = 0; n < 4; n++) edge_tab.push_back(gen_row(r));
    end
    foreach (edge_tab[t]) begin
      inst_v = edge_tab[t];
      stim_q = '{inst_v};
      run_stream(100);
      if (got_w.size() >= 1) begin
        chk($sformatf("rt_pad_%h", inst_v), got_w[0][31:16], 16'h0001);
        chk($sformatf("rt_decode_%h", inst_v), expand(got_w[0][15:0]), inst_v);
      end
    end

    // Near-miss instructions must pass through unchanged
    nc_tab = '{mk_i(128, 10, 2, 9, 'h03), mk_i(2, 10, 2, 9, 'h03), mk_i(4, 10, 2, 5, 'h03),
               mk_s(128, 9, 8, 2, 'h23), mk_i(0, 8, 0, 8, 'h13), mk_i(32, 8, 0, 8, 'h13),
               mk_i(1, 9, 0, 8, 'h13), mk_u(1, 2, 'h37), mk_u(32, 5, 'h37),
               mk_i(0, 5, 1, 5, 'h13), mk_i(1024, 8, 5, 8, 'h13), mk_i(3, 5, 5, 5, 'h13),
               32'h008000EF, 32'h00940463, mk_i(4, 5, 0, 1, 'h67), mk_i(0, 1, 0, 0, 'h67),
               32'h007302B3, mk_i(32, 8, 7, 8, 'h13), mk_r(32, 10, 9, 0, 8, 'h33)};
    foreach (nc_tab[t]) begin
      inst_v = nc_tab[t];
      stim_q = '{inst_v};
      run_stream(100);
      if (got_w.size() >= 1) chk($sformatf("pass_%h", inst_v), got_w[0], inst_v);
    end

    // Random mixed streams with random backpressure
    for (int s = 0; s < 25; s++) begin
      int len;
      len = int'($urandom_range(1, 12));
      stim_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) stim_q.push_back(gen_row(int'($urandom_range(0, 13))));
        else stim_q.push_back($urandom);
      end
      run_stream(int'($urandom_range(30, 100)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
